seg7_bus_decoder: RTL and testbench
===================================

Name: seg7_bus_decoder

Overview:
- Receiver side of the team's 4-digit multiplexed 7-segment display bus: passively snoops the 12-bit segment/enable bus and recovers the value, decimal point and error status of each digit.
- Used by bench checkers and by self-test logic to confirm what the display drivers actually show.
- Samples the bus and filters glitches with a stability counter, decodes each active digit, then publishes one complete 4-digit frame at a time with a single-cycle strobe.

Parameters:
- STABLE_CYC, 4: consecutive identical samples required before a digit is captured (legal range 1..255).
- TIMEOUT_CYC, 1000000: cycles with no capture before the stale flag sets (legal range 1..2^24-1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- segs  input  12  display bus. Polarity is active-low throughout (0 = lit or enabled).
  - [6:0]: segments a..g, with bit 0 = a and bit 6 = g.
  - [7]: decimal point.
  - [11:8]: digit enables for digit 0..3 respectively.
- digits  output  16  decoded values, 4 bits per digit; digit n occupies [4n+3:4n].
- dps  output  4  decimal point lit per digit (1 = lit).
- errs  output  4  per-digit flag: segment pattern was not a legal glyph.
- frame_valid  output  1  one-cycle pulse when digits, dps and errs update.
- stale  output  1  set when no capture has occurred for TIMEOUT_CYC cycles.

Behaviour:
- Interface is fixed: one clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Input registration:
  - segs is registered into s_q every cycle.
  - All decisions use s_q and the previous sample s_qq.
- A sample is valid when exactly one bit of s_q[11:8] is 0.
  - All-ones (no digit enabled) is invalid.
  - Two or more enables low is invalid.
- Decode table for s_q[6:0], mapping pattern to value:
  - 0x40 -> 0, 0x79 -> 1, 0x24 -> 2, 0x30 -> 3, 0x19 -> 4.
  - 0x12 -> 5, 0x02 -> 6, 0x78 -> 7, 0x00 -> 8, 0x10 -> 9.
  - 0x7F (blank) -> 0xE, with err=0.
  - Any other pattern -> 0xF, with err=1.
- dp captured = ~s_q[7].
- FSM states WAIT, SETTLE, HOLD; cnt is 8 bits.
  - WAIT: on a valid sample, go to SETTLE with cnt=1. Otherwise stay in WAIT.
  - SETTLE, when s_q != s_qq: if s_q is valid, stay in SETTLE with cnt=1; otherwise go to WAIT.
  - SETTLE, when s_q == s_qq: cnt increments. When cnt reaches STABLE_CYC, capture into the shadow slot of the enabled digit, set seen[idx], and go to HOLD.
  - STABLE_CYC=1: capture occurs on the first valid sample, and WAIT goes directly to HOLD.
  - HOLD: stay while s_q == s_qq, so a static bus never captures twice. On any change, go to SETTLE (cnt=1) if the new sample is valid, otherwise to WAIT.
- Capture latency:
  - With the bus held constant from cycle t, segs is registered at t+1.
  - The shadow slot is written at the end of cycle t+STABLE_CYC.
- Frame assembly:
  - seen[3:0] tracks which digits have been captured since the last frame.
  - Capturing an already-seen digit overwrites its shadow slot (latest wins).
  - When a capture makes seen==4'b1111: on the following cycle, frame_valid=1, digits/dps/errs load from the shadow slots, and seen clears.
  - A capture occurring in that same following cycle counts toward the next frame.
- Outputs hold their values between frames.
- Stale logic:
  - 24-bit idle counter increments each cycle without a capture and saturates.
  - stale=1 when counter >= TIMEOUT_CYC.
  - Any capture clears the counter and stale in the same cycle.
- Reset:
  - Outputs: digits=0, dps=0, errs=0, frame_valid=0, stale=0.
  - Internal: seen=0, FSM=WAIT, cnt=0, shadow slots=0, s_q=s_qq=12'hFFF, idle counter=0.
  - Reset mid-frame discards all partial captures.

Test Plan:
- Reset mid-frame: assert reset after 2 captures, then drive 4 fresh digits -> exactly one frame_valid, and it contains only post-reset values.
- Basic frame, STABLE_CYC=4: drive each digit for 6 cycles.
  - Stimulus: enables 0xE,0xD,0xB,0x7 with patterns 0x79,0x24,0x30,0x19.
  - Required: frame_valid pulses once; digits=16'h4321, errs=0, dps=0.
- Glitch rejection: hold digit 1 pattern 0x12 for 3 cycles, then change to 0x02 for 5 cycles -> digit 1 captures 6, not 5.
- Invalid enables and duplicates:
  - Enables 0xC, or 0xF, held 10 cycles -> no capture.
  - Digit 2 shown twice (0x40 then 0x78) before the frame completes -> digits[11:8]=7.
- Error, blank and dp on one frame: digit 3 pattern 0x55, digit 0 pattern 0x7F, segs[7]=0 on digit 1 -> errs=4'b1000, digits[3:0]=0xE, digits[15:12]=0xF, dps=4'b0010.
- Stale, TIMEOUT_CYC=20: bus idle for 25 cycles -> stale rises after 20 cycles without capture; the next capture clears it.

Source files
------------

// File: rtl/seg7_bus_decoder_if.sv
// Bundle for the snooped 7-segment display bus and the decoded frame it yields.
// frame_valid is a one-cycle strobe with no ready: the decoder is passive and a frame is lost if not taken.
interface seg7_bus_decoder_if;
  logic [11:0] segs;
  logic [15:0] digits;
  logic [3:0]  dps;
  logic [3:0]  errs;
  logic        frame_valid;
  logic        stale;

  modport master (output segs, input digits, dps, errs, frame_valid, stale);
  modport slave  (input segs, output digits, dps, errs, frame_valid, stale);
endinterface

// File: rtl/seg7_bus_decoder.sv
// Passive receiver for the 4-digit multiplexed 7-segment bus: debounces each digit,
// decodes its glyph, and publishes whole 4-digit frames with a one-cycle strobe.
module seg7_bus_decoder #(
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seg7_bus_decoder_if.slave    bus,
  output logic [1:0]           dbgState
);

  localparam logic [1:0] ST_WAIT   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  localparam logic [7:0]  STABLE_C  = 8'(STABLE_CYC);
  localparam logic [23:0] TIMEOUT_C = 24'(TIMEOUT_CYC);
  localparam bit          ONE_SHOT  = (STABLE_CYC == 1);

  logic [11:0] sQ, sQq;
  logic [1:0]  state, stateNxt;
  logic [7:0]  cnt, cntNxt, cntInc;
  logic [3:0]  seen, seenNxt;
  logic [15:0] shDigits, shDigitsNxt;
  logic [3:0]  shDps, shDpsNxt, shErrs, shErrsNxt;
  logic [23:0] idle, idleInc;
  logic        sampleValid, changed, capture, frameDone;
  logic [1:0]  capIdx;
  logic [4:0]  glyph;

  function automatic logic [4:0] decodeGlyph(input logic [6:0] pat);
    case (pat)
      7'h40:   decodeGlyph = 5'h00;
      7'h79:   decodeGlyph = 5'h01;
      7'h24:   decodeGlyph = 5'h02;
      7'h30:   decodeGlyph = 5'h03;
      7'h19:   decodeGlyph = 5'h04;
      7'h12:   decodeGlyph = 5'h05;
      7'h02:   decodeGlyph = 5'h06;
      7'h78:   decodeGlyph = 5'h07;
      7'h00:   decodeGlyph = 5'h08;
      7'h10:   decodeGlyph = 5'h09;
      7'h7F:   decodeGlyph = 5'h0E;
      default: decodeGlyph = 5'h1F;
    endcase
  endfunction

  // Exactly one active-low enable makes a usable sample.
  always_comb begin
    sampleValid = 1'b1;
    capIdx      = 2'd0;
    case (sQ[11:8])
      4'b1110: capIdx = 2'd0;
      4'b1101: capIdx = 2'd1;
      4'b1011: capIdx = 2'd2;
      4'b0111: capIdx = 2'd3;
      default: sampleValid = 1'b0;
    endcase
  end

  assign glyph   = decodeGlyph(sQ[6:0]);
  assign changed = (sQ != sQq);
  assign cntInc  = cnt + 8'd1;
  assign idleInc = (idle == 24'hFF_FFFF) ? idle : idle + 24'd1;

  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    capture  = 1'b0;
    case (state)
      ST_WAIT: begin
        if (sampleValid) begin
          cntNxt   = 8'd1;
          capture  = ONE_SHOT;
          stateNxt = ONE_SHOT ? ST_HOLD : ST_SETTLE;
        end
      end
      ST_SETTLE, ST_HOLD: begin
        if (changed) begin
          if (sampleValid) begin
            cntNxt   = 8'd1;
            capture  = ONE_SHOT;
            stateNxt = ONE_SHOT ? ST_HOLD : ST_SETTLE;
          end else begin
            stateNxt = ST_WAIT;
          end
        end else if (state == ST_SETTLE) begin
          // HOLD ignores a static bus so one display period yields one capture.
          cntNxt = cntInc;
          if (cntInc == STABLE_C) begin
            capture  = 1'b1;
            stateNxt = ST_HOLD;
          end
        end
      end
      default: stateNxt = ST_WAIT;
    endcase
  end

  always_comb begin
    shDigitsNxt = shDigits;
    shDpsNxt    = shDps;
    shErrsNxt   = shErrs;
    seenNxt     = seen;
    if (capture) begin
      shDigitsNxt[{capIdx, 2'b00} +: 4] = glyph[3:0];
      shDpsNxt[capIdx]                  = ~sQ[7];
      shErrsNxt[capIdx]                 = glyph[4];
      seenNxt[capIdx]                   = 1'b1;
    end
  end

  assign frameDone = capture && (seenNxt == 4'hF);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sQ              <= 12'hFFF;
      sQq             <= 12'hFFF;
      state           <= ST_WAIT;
      cnt             <= 8'd0;
      seen            <= 4'd0;
      shDigits        <= 16'd0;
      shDps           <= 4'd0;
      shErrs          <= 4'd0;
      idle            <= 24'd0;
      bus.digits      <= 16'd0;
      bus.dps         <= 4'd0;
      bus.errs        <= 4'd0;
      bus.frame_valid <= 1'b0;
      bus.stale       <= 1'b0;
    end else begin
      sQ              <= bus.segs;
      sQq             <= sQ;
      state           <= stateNxt;
      cnt             <= cntNxt;
      shDigits        <= shDigitsNxt;
      shDps           <= shDpsNxt;
      shErrs          <= shErrsNxt;
      bus.frame_valid <= frameDone;
      // Publishing from the next-state shadow lets the completing capture land in this frame.
      if (frameDone) begin
        seen       <= 4'd0;
        bus.digits <= shDigitsNxt;
        bus.dps    <= shDpsNxt;
        bus.errs   <= shErrsNxt;
      end else begin
        seen <= seenNxt;
      end
      if (capture) begin
        idle      <= 24'd0;
        bus.stale <= 1'b0;
      end else begin
        idle      <= idleInc;
        bus.stale <= (idleInc >= TIMEOUT_C);
      end
    end
  end

  assign dbgState = state;

endmodule

// File: tb/tb_seg7_bus_decoder.sv
// Self-checking bench for seg7_bus_decoder: a reference model predicts frames into
// an expected queue that a negedge monitor drains whenever frame_valid pulses.
module tb_seg7_bus_decoder;
  localparam int STABLE  = 4;
  localparam int TIMEOUT = 20;
  localparam int W       = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_bus_decoder_if bus ();
  seg7_bus_decoder_if bus1 ();
  logic [1:0] dbgState, dbgState1;

  assign bus1.segs = bus.segs;

  seg7_bus_decoder #(.STABLE_CYC(STABLE), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbgState(dbgState));

  seg7_bus_decoder #(.STABLE_CYC(1), .TIMEOUT_CYC(TIMEOUT)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .dbgState(dbgState1));

  int errCnt = 0;
  int chkCnt = 0;
  logic [W-1:0] expQ[$];
  logic [W-1:0] exp1Q[$];
  logic chk1 = 1'b0;

  logic [15:0] mDigits;
  logic [3:0]  mDps, mErrs, mSeen;
  logic [11:0] lastSegs;
  logic [6:0]  patTab[12] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                              7'h02, 7'h78, 7'h00, 7'h10, 7'h7F, 7'h55};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chkCnt++;
    if (act !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] glyphModel(input logic [6:0] pat);
    case (pat)
      7'h40: return 5'h00;  7'h79: return 5'h01;  7'h24: return 5'h02;
      7'h30: return 5'h03;  7'h19: return 5'h04;  7'h12: return 5'h05;
      7'h02: return 5'h06;  7'h78: return 5'h07;  7'h00: return 5'h08;
      7'h10: return 5'h09;  7'h7F: return 5'h0E;
      default: return 5'h1F;
    endcase
  endfunction

  function automatic int enIdx(input logic [3:0] en);
    case (en)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Holds one bus value for a number of cycles and predicts whether it is captured.
  task automatic driveRaw(input logic [3:0] en, input logic dp, input logic [6:0] pat, input int cycles);
    logic [11:0] v;
    logic [4:0]  g;
    int idx;
    v = {en, ~dp, pat};
    bus.segs = v;
    idx = enIdx(en);
    if (idx >= 0 && cycles >= STABLE && v != lastSegs) begin
      g = glyphModel(pat);
      mDigits[idx*4 +: 4] = g[3:0];
      mErrs[idx] = g[4];
      mDps[idx]  = dp;
      mSeen[idx] = 1'b1;
      if (mSeen == 4'hF) begin
        expQ.push_back({mDigits, mDps, mErrs});
        mSeen = 4'h0;
      end
    end
    lastSegs = v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic idleBus(input int cycles);
    driveRaw(4'hF, 1'b0, 7'h7F, cycles);
  endtask

  task automatic doReset();
    bus.segs = 12'hFFF;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mDigits = 16'h0; mDps = 4'h0; mErrs = 4'h0; mSeen = 4'h0;
    lastSegs = 12'hFFF;
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && bus.frame_valid) begin
      check("frame_pending", (expQ.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check("digits", 32'(bus.digits), 32'(e[23:8]));
        check("dps", 32'(bus.dps), 32'(e[7:4]));
        check("errs", 32'(bus.errs), 32'(e[3:0]));
      end
    end
    if (rst_n && chk1 && bus1.frame_valid) begin
      check("s1_frame_pending", (exp1Q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp1Q.size() > 0) begin
        e = exp1Q.pop_front();
        check("s1_digits", 32'(bus1.digits), 32'(e[23:8]));
        check("s1_dps", 32'(bus1.dps), 32'(e[7:4]));
        check("s1_errs", 32'(bus1.errs), 32'(e[3:0]));
      end
    end
  end

  initial begin
    logic [3:0] en;
    logic [6:0] pat;
    logic dp;
    bus.segs = 12'hFFF;
    doReset();
    check("rst_digits", 32'(bus.digits), 32'h0);
    check("rst_dps", 32'(bus.dps), 32'h0);
    check("rst_errs", 32'(bus.errs), 32'h0);
    check("rst_fv", 32'(bus.frame_valid), 32'h0);
    check("rst_stale", 32'(bus.stale), 32'h0);
    check("rst_state", 32'(dbgState), 32'h0);
    check("rst_s1_digits", 32'(bus1.digits), 32'h0);

    // Basic frame
    driveRaw(4'hE, 1'b0, 7'h79, 6);
    driveRaw(4'hD, 1'b0, 7'h24, 6);
    driveRaw(4'hB, 1'b0, 7'h30, 6);
    driveRaw(4'h7, 1'b0, 7'h19, 6);
    idleBus(3);
    check("basic_digits", 32'(bus.digits), 32'h4321);
    check("basic_errs", 32'(bus.errs), 32'h0);
    check("basic_dps", 32'(bus.dps), 32'h0);
    check("basic_drained", expQ.size(), 0);

    // Glitch, invalid enables, duplicate digit
    driveRaw(4'hE, 1'b0, 7'h40, 6);
    driveRaw(4'hD, 1'b0, 7'h12, 3);
    driveRaw(4'hD, 1'b0, 7'h02, 5);
    driveRaw(4'hC, 1'b0, 7'h40, 10);
    driveRaw(4'hF, 1'b0, 7'h40, 10);
    driveRaw(4'hB, 1'b0, 7'h40, 6);
    driveRaw(4'hB, 1'b0, 7'h78, 6);
    driveRaw(4'h7, 1'b0, 7'h00, 6);
    idleBus(3);
    check("glitch_d1", 32'(bus.digits[7:4]), 32'h6);
    check("dup_d2", 32'(bus.digits[11:8]), 32'h7);
    check("glitch_drained", expQ.size(), 0);

    // Error, blank and decimal point
    driveRaw(4'hE, 1'b0, 7'h7F, 6);
    driveRaw(4'hD, 1'b1, 7'h40, 6);
    driveRaw(4'hB, 1'b0, 7'h79, 6);
    driveRaw(4'h7, 1'b0, 7'h55, 6);
    idleBus(3);
    check("edp_errs", 32'(bus.errs), 32'h8);
    check("edp_digits", 32'(bus.digits), 32'hF10E);
    check("edp_dps", 32'(bus.dps), 32'h2);
    check("edp_drained", expQ.size(), 0);

    // Randomised frames with glitches and invalid enables mixed in
    for (int f = 0; f < 4; f++) begin
      for (int d = 0; d < 4; d++) begin
        en  = ~(4'b0001 << d);
        pat = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : patTab[$urandom_range(0, 11)];
        dp  = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 2) == 0) driveRaw(4'h3, 1'b0, pat, $urandom_range(1, 5));
        if ($urandom_range(0, 2) == 0) driveRaw(en, dp, pat ^ 7'h01, $urandom_range(1, STABLE - 1));
        driveRaw(en, dp, pat, $urandom_range(STABLE, STABLE + 3));
      end
    end
    idleBus(3);
    check("rand_drained", expQ.size(), 0);

    // Reset mid-frame
    driveRaw(4'hE, 1'b0, 7'h10, 6);
    driveRaw(4'hD, 1'b0, 7'h10, 6);
    check("mid_no_frame", expQ.size(), 0);
    doReset();
    check("mid_rst_digits", 32'(bus.digits), 32'h0);
    driveRaw(4'hB, 1'b0, 7'h12, 6);
    driveRaw(4'h7, 1'b0, 7'h02, 6);
    driveRaw(4'hE, 1'b0, 7'h78, 6);
    driveRaw(4'hD, 1'b0, 7'h30, 6);
    idleBus(3);
    check("mid_digits", 32'(bus.digits), 32'h6537);
    check("mid_drained", expQ.size(), 0);

    // Single-cycle capture instance
    doReset();
    chk1 = 1'b1;
    exp1Q.push_back({16'h7269, 4'h0, 4'h0});
    driveRaw(4'hE, 1'b0, 7'h10, 1);
    driveRaw(4'hD, 1'b0, 7'h02, 1);
    driveRaw(4'hB, 1'b0, 7'h24, 1);
    driveRaw(4'h7, 1'b0, 7'h78, 1);
    idleBus(3);
    chk1 = 1'b0;
    check("s1_drained", exp1Q.size(), 0);
    check("s4_no_capture", 32'(bus.digits), 32'h0);

    // Stale timeout
    doReset();
    check("stale_rst", 32'(bus.stale), 32'h0);
    driveRaw(4'hE, 1'b0, 7'h40, 6);
    check("hold_state", 32'(dbgState), 32'h2);
    idleBus(18);
    check("stale_19", 32'(bus.stale), 32'h0);
    idleBus(1);
    check("stale_20", 32'(bus.stale), 32'h1);
    idleBus(5);
    driveRaw(4'hD, 1'b0, 7'h79, 4);
    check("stale_pre_cap", 32'(bus.stale), 32'h1);
    @(posedge clk);
    #1;
    check("stale_cleared", 32'(bus.stale), 32'h0);
    idleBus(3);
    check("final_drained", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
